// File: rtl/eth_tx_framer.sv
// rtl/eth_tx_framer.sv - GMII-style Ethernet transmit framer: preamble/SFD, payload from FWFT queue, pad, CRC-32 FCS, IFG
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   len_valid/len/len_ready  frame descriptor handshake (payload byte count)
//   q_dout/q_empty/q_rd_en   first-word fall-through upstream byte queue
//   tx_en/tx_er/txd       registered GMII-style transmit outputs
//   underrun              one-cycle pulse alongside tx_er when the queue runs dry mid-payload
//   busy                  high whenever the framer is not idle
module eth_tx_framer #(
  parameter int LEN_WIDTH   = 11,
  parameter int MIN_PAYLOAD = 60,
  parameter int IFG_BYTES   = 12
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 len_valid,
  input  logic [LEN_WIDTH-1:0] len,
  output logic                 len_ready,
  input  logic [7:0]           q_dout,
  input  logic                 q_empty,
  output logic                 q_rd_en,
  output logic                 tx_en,
  output logic                 tx_er,
  output logic [7:0]           txd,
  output logic                 underrun,
  output logic                 busy
);

  typedef enum logic [2:0] {
    IDLE, PREAMBLE, SFD, PAYLOAD, PAD, FCS, DRAIN, IFG
  } state_t;

  localparam logic [LEN_WIDTH-1:0] ONE      = LEN_WIDTH'(1);
  localparam logic [LEN_WIDTH-1:0] PRE_LAST = LEN_WIDTH'(6);
  localparam logic [LEN_WIDTH-1:0] FCS_LAST = LEN_WIDTH'(3);

  state_t               state, state_n;
  logic [LEN_WIDTH-1:0] cnt, cnt_n;   // phase index: preamble, payload+pad, FCS byte, IFG cycle
  logic [LEN_WIDTH-1:0] rem, rem_n;   // payload bytes still to be popped
  logic [31:0]          crc, crc_n;
  logic                 tx_en_n, tx_er_n, underrun_n;
  logic [7:0]           txd_n;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'd0, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    end
    return r;
  endfunction

  // Each state decides the byte that appears on the registered outputs in the
  // following cycle, so the handshake cycle in IDLE already issues the first
  // preamble byte and PREAMBLE only has to issue the remaining six.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    rem_n      = rem;
    crc_n      = crc;
    tx_en_n    = 1'b0;
    tx_er_n    = 1'b0;
    txd_n      = 8'h00;
    underrun_n = 1'b0;
    q_rd_en    = 1'b0;
    len_ready  = 1'b0;

    case (state)
      IDLE: begin
        len_ready = 1'b1;
        if (len_valid) begin
          state_n = PREAMBLE;
          tx_en_n = 1'b1;
          txd_n   = 8'h55;
          cnt_n   = ONE;
          rem_n   = len;
          crc_n   = 32'hFFFF_FFFF;
        end
      end

      PREAMBLE: begin
        tx_en_n = 1'b1;
        txd_n   = 8'h55;
        cnt_n   = cnt + 1'b1;
        if (cnt == PRE_LAST) begin
          state_n = SFD;
          cnt_n   = '0;
        end
      end

      SFD: begin
        tx_en_n = 1'b1;
        txd_n   = 8'hD5;
        cnt_n   = '0;
        if (rem != '0)           state_n = PAYLOAD;
        else if (MIN_PAYLOAD > 0) state_n = PAD;
        else                     state_n = FCS;
      end

      PAYLOAD: begin
        tx_en_n = 1'b1;
        if (!q_empty) begin
          q_rd_en = 1'b1;
          txd_n   = q_dout;
          crc_n   = crc_byte(crc, q_dout);
          cnt_n   = cnt + 1'b1;
          rem_n   = rem - 1'b1;
          if (rem == ONE) begin
            if (int'(cnt_n) < MIN_PAYLOAD) begin
              state_n = PAD;
            end else begin
              state_n = FCS;
              cnt_n   = '0;
            end
          end
        end else begin
          // Starved with bytes still owed: poison the frame and discard the rest.
          tx_er_n    = 1'b1;
          underrun_n = 1'b1;
          state_n    = DRAIN;
        end
      end

      PAD: begin
        tx_en_n = 1'b1;
        crc_n   = crc_byte(crc, 8'h00);
        cnt_n   = cnt + 1'b1;
        if (int'(cnt_n) >= MIN_PAYLOAD) begin
          state_n = FCS;
          cnt_n   = '0;
        end
      end

      FCS: begin
        tx_en_n = 1'b1;
        case (cnt[1:0])
          2'd0:    txd_n = ~crc[7:0];
          2'd1:    txd_n = ~crc[15:8];
          2'd2:    txd_n = ~crc[23:16];
          default: txd_n = ~crc[31:24];
        endcase
        cnt_n = cnt + 1'b1;
        if (cnt == FCS_LAST) begin
          state_n = IFG;
          cnt_n   = '0;
        end
      end

      DRAIN: begin
        if (!q_empty) begin
          q_rd_en = 1'b1;
          rem_n   = rem - 1'b1;
          if (rem == ONE) begin
            state_n = IFG;
            cnt_n   = '0;
          end
        end
      end

      IFG: begin
        cnt_n = cnt + 1'b1;
        if (int'(cnt) >= IFG_BYTES - 1) begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      end

      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      rem      <= '0;
      crc      <= '0;
      tx_en    <= 1'b0;
      tx_er    <= 1'b0;
      txd      <= 8'h00;
      underrun <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      rem      <= rem_n;
      crc      <= crc_n;
      tx_en    <= tx_en_n;
      tx_er    <= tx_er_n;
      txd      <= txd_n;
      underrun <= underrun_n;
    end
  end

  assign busy = (state != IDLE);

endmodule
